// File: rtl/sync_fifo_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ext_if
// Brief    : Control, data and status bundle for sync_fifo_ext.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_ext_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             clr_err;
  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, w_en, data_in, r_en,
    input  data_out, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, w_en, data_in, r_en,
    output data_out, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ext
// Brief    : Single-clock FIFO, registered or FWFT read, with occupancy,
//            threshold flags, sticky error flags and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ext #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 10,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  sync_fifo_ext_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;

  assign w_full     = (r_count == c_full_cnt);
  assign w_empty    = (r_count == '0);
  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  assign w_rd_acc   = bus.r_en & ~w_empty;
  assign w_wr_acc   = bus.w_en & (~w_full | w_rd_acc);
  assign w_wptr_nxt = (r_wptr == c_ptr_last) ? '0 : r_wptr + PW'(1);
  assign w_rptr_nxt = (r_rptr == c_ptr_last) ? '0 : r_rptr + PW'(1);

  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.flush) begin
      r_mem[r_wptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_wr_acc) r_wptr <= w_wptr_nxt;
        if (w_rd_acc) r_rptr <= w_rptr_nxt;
        case ({w_wr_acc, w_rd_acc})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      r_overflow  <= (bus.w_en & ~w_wr_acc) | (r_overflow  & ~bus.clr_err);
      r_underflow <= (bus.r_en & ~w_rd_acc) | (r_underflow & ~bus.clr_err);
    end
  end

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (32'(r_count) >= AF_THRESH);
  assign bus.almost_empty = (32'(r_count) <= AE_THRESH);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = r_mem[r_rptr];
      assign bus.rd_valid = ~w_empty;
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_dout;
      logic             r_rd_valid;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_dout     <= '0;
          r_rd_valid <= 1'b0;
        end else if (bus.flush) begin
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_dout     <= r_mem[r_rptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign bus.data_out = r_dout;
      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ext
// Brief    : Directed scoreboard bench driving a registered-read and an FWFT
//            instance of sync_fifo_ext with identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ext;
  logic       clk = 1'b0;
  logic       rstn;
  logic       flush, clr_err, w_en, r_en;
  logic [7:0] data_in;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m0_exp, m1_exp;

  always #5 clk = ~clk;

  sync_fifo_ext_if #(.WIDTH(8), .DEPTH(10)) if0 ();
  sync_fifo_ext_if #(.WIDTH(8), .DEPTH(10)) if1 ();

  assign if0.flush = flush;   assign if1.flush = flush;
  assign if0.clr_err = clr_err; assign if1.clr_err = clr_err;
  assign if0.w_en = w_en;     assign if1.w_en = w_en;
  assign if0.r_en = r_en;     assign if1.r_en = r_en;
  assign if0.data_in = data_in; assign if1.data_in = data_in;

  sync_fifo_ext #(.WIDTH(8), .DEPTH(10), .FWFT(0)) u_reg  (.clk(clk), .rstn(rstn), .bus(if0.slave));
  sync_fifo_ext #(.WIDTH(8), .DEPTH(10), .FWFT(1)) u_fwft (.clk(clk), .rstn(rstn), .bus(if1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    q0.push_back(d);
    q1.push_back(d);
  endtask

  // Monitor: registered instance pops on rd_valid, FWFT instance on an accepted pop.
  always @(negedge clk) begin
    if (rstn === 1'b1 && if0.rd_valid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rd_reg_unexpected: got 0x%0h expected no read", if0.data_out);
      end else begin
        m0_exp = q0.pop_front();
        if (if0.data_out !== m0_exp) begin
          errors++;
          $display("FAIL rd_reg_data: got 0x%0h expected 0x%0h", if0.data_out, m0_exp);
        end
      end
    end
    if (rstn === 1'b1 && r_en === 1'b1 && if1.rd_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd_fwft_unexpected: got 0x%0h expected no read", if1.data_out);
      end else begin
        m1_exp = q1.pop_front();
        if (if1.data_out !== m1_exp) begin
          errors++;
          $display("FAIL rd_fwft_data: got 0x%0h expected 0x%0h", if1.data_out, m1_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; clr_err = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cyc();
    chk("rst_empty",     32'(if0.empty), 1);
    chk("rst_aempty",    32'(if0.almost_empty), 1);
    chk("rst_full",      32'(if0.full), 0);
    chk("rst_afull",     32'(if0.almost_full), 0);
    chk("rst_count",     32'(if0.count), 0);
    chk("rst_dout",      32'(if0.data_out), 0);
    chk("rst_rdv_reg",   32'(if0.rd_valid), 0);
    chk("rst_rdv_fwft",  32'(if1.rd_valid), 0);
    chk("rst_ovf",       32'(if0.overflow), 0);
    chk("rst_udf",       32'(if0.underflow), 0);

    // Fill with 0x01..0x0A, checking thresholds on the way up.
    for (int i = 1; i <= 10; i++) begin
      w_en = 1'b1; data_in = 8'(i); push(8'(i));
      cyc();
      if (i == 2) chk("cnt2_aempty", 32'(if0.almost_empty), 1);
      if (i == 3) chk("cnt3_aempty", 32'(if0.almost_empty), 0);
      if (i == 7) chk("cnt7_afull",  32'(if0.almost_full), 0);
      if (i == 8) chk("cnt8_afull",  32'(if0.almost_full), 1);
    end
    data_in = 8'hFF;
    cyc();
    w_en = 1'b0;
    chk("full_flag",  32'(if0.full), 1);
    chk("full_count", 32'(if0.count), 10);
    chk("full_ovf",   32'(if0.overflow), 1);
    chk("fwft_ovf",   32'(if1.overflow), 1);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("ovf_clr", 32'(if0.overflow), 0);

    // Simultaneous read/write on a full FIFO.
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'h11 + i); push(8'(8'h11 + i));
      cyc();
      chk("full_rw_count", 32'(if0.count), 10);
    end
    w_en = 1'b0;
    chk("full_rw_ovf", 32'(if0.overflow), 0);

    // Drain, crossing the read-pointer wrap, then one read too many.
    for (int i = 0; i < 10; i++) cyc();
    chk("drain_count", 32'(if0.count), 0);
    chk("drain_empty", 32'(if0.empty), 1);
    cyc();
    r_en = 1'b0;
    chk("drain_udf", 32'(if0.underflow), 1);
    cyc();
    chk("drain_rdv_idle", 32'(if0.rd_valid), 0);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("udf_clr", 32'(if0.underflow), 0);

    // Registered read latency.
    w_en = 1'b1; data_in = 8'h5A; push(8'h5A); cyc(); w_en = 1'b0;
    r_en = 1'b1; cyc(); r_en = 1'b0;
    chk("lat_rdv",  32'(if0.rd_valid), 1);
    chk("lat_data", 32'(if0.data_out), 32'h5A);
    cyc();
    chk("lat_rdv_pulse", 32'(if0.rd_valid), 0);
    r_en = 1'b1; clr_err = 1'b1; cyc(); r_en = 1'b0; clr_err = 1'b0;
    chk("udf_set_wins", 32'(if0.underflow), 1);
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    chk("udf_clr2", 32'(if0.underflow), 0);

    // Simultaneous read/write on an empty FIFO.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h33; push(8'h33);
    cyc();
    w_en = 1'b0; r_en = 1'b0;
    chk("empty_rw_count", 32'(if0.count), 1);
    chk("empty_rw_udf",   32'(if0.underflow), 1);
    r_en = 1'b1; cyc(); r_en = 1'b0;
    cyc();
    clr_err = 1'b1; cyc(); clr_err = 1'b0;

    // Flush with six words stored.
    for (int i = 0; i < 6; i++) begin
      w_en = 1'b1; data_in = 8'(8'h61 + i); cyc();
    end
    w_en = 1'b0;
    chk("pre_flush_count", 32'(if0.count), 6);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_count",    32'(if0.count), 0);
    chk("flush_empty",    32'(if0.empty), 1);
    chk("flush_rdv_fwft", 32'(if1.rd_valid), 0);
    chk("flush_rdv_reg",  32'(if0.rd_valid), 0);
    w_en = 1'b1; data_in = 8'h77; push(8'h77); cyc(); w_en = 1'b0;
    r_en = 1'b1; cyc(); r_en = 1'b0;
    cyc();

    // Asynchronous reset in the middle of a write burst.
    w_en = 1'b1; data_in = 8'hA1; cyc();
    data_in = 8'hA2; cyc();
    chk("burst_count", 32'(if0.count), 2);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_count", 32'(if0.count), 0);
    chk("async_rst_empty", 32'(if1.empty), 1);
    w_en = 1'b0;
    #2 rstn = 1'b1;
    repeat (3) cyc();

    chk("sb_reg_drained",  32'(q0.size()), 0);
    chk("sb_fwft_drained", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Single-clock FIFO with parametrised width and depth, and a selectable read mode (registered or first-word-fall-through). It adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. It is the general-purpose buffering block used between producer and consumer stages in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, need not be a power of two)
FWFT, 0, 0 = registered read (data one cycle after accept); 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and pointers
clr_err  in  1  synchronous clear of the sticky error flags
w_en  in  1  write request
data_in  in  WIDTH  write data
r_en  in  1  read request (FWFT=1: pop/acknowledge of the head word)
data_out  out  WIDTH  read data
rd_valid  out  1  FWFT=0: one-cycle pulse, data_out updated; FWFT=1: equals !empty
count  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rstn low, asynchronous): pointers = 0, count = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0. As a result empty = 1, almost_empty = 1, full = 0, almost_full = 0. Memory contents are not reset.
- Only one always-block drives each register. The write, read and count paths are resolved together; no multiple-driver structure.
- Acceptance uses state at the start of the cycle:
  - wr_acc = w_en & (!full | rd_acc)
  - rd_acc = r_en & !empty
- When full, a simultaneous read and write are both accepted and count is unchanged.
- When empty, a simultaneous read and write: the write is accepted, the read is rejected, and underflow is set.
- count next value: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1 (explicit compare, not binary overflow).
- FWFT=0 read path:
  - On rd_acc, data_out <= mem[r_ptr] and rd_valid = 1 for the next cycle.
  - Otherwise rd_valid = 0 and data_out holds its value.
  - Read latency is 1 cycle.
- FWFT=1 read path:
  - data_out = mem[r_ptr] combinationally, rd_valid = !empty.
  - A written word is visible the cycle after the write edge.
  - r_en pops the word.
- All flags are combinational from count, so they update in the cycle after the accepting edge.
- overflow is set on w_en & !wr_acc. underflow is set on r_en & !rd_acc.
- Both error flags stay set until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- flush: has priority over reads and writes in that cycle. Pointers and count go to 0, rd_valid goes to 0, and data_out holds. Error flags are unaffected.
- Rejected operations never change pointers, count or memory.

Test Plan:
- Reset then idle, defaults -> empty=1, almost_empty=1, full=0, count=0, data_out=0, rd_valid=0. Asserting rstn low mid-burst clears count immediately, without waiting for a clock edge.
- Write 0x01..0x0A (10 words), then an 11th write of 0xFF -> full=1, count=10, overflow=1. Reading all 10 returns 0x01..0x0A in order, and 0xFF is never seen.
- FWFT=0: write 0x5A, then r_en -> data_out=0x5A and rd_valid=1 exactly one cycle after the r_en edge. A further r_en while empty sets underflow=1, and clr_err clears it.
- Full FIFO with w_en=r_en=1 for 5 cycles -> count stays 10, no overflow, and read order continues correctly across the pointer wrap at index 9->0.
- Empty FIFO with w_en=r_en=1 and data_in 0x33 -> count=1, underflow=1; the next read returns 0x33.
- Thresholds at defaults: count 2 -> almost_empty=1, count 3 -> almost_empty=0, count 8 -> almost_full=1. With 6 words stored, flush gives count=0 and empty=1 next cycle; FWFT=1 then shows rd_valid=0.
